// File: rtl/avalon_pio_pkg.sv
// Shared definitions for the debounced key PIO: register word addresses
// and a constant-foldable ceil(log2) used to size the debounce counters.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] ADDR_RAW      = 3'd5;

  // Smallest n with 2**n >= value; callers pass value >= 2 so the result is >= 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One input bit: metastability synchroniser, hold-time debounce filter and
// one-cycle rise/fall pulses derived from the accepted (debounced) level.
module key_debounce
  import avalon_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit INIT_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_count;
  logic                   r_level;
  logic                   r_levelPrev;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Shift the asynchronous pin through the synchroniser chain; it idles at the key's rest level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end
  end

  // Accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_level <= INIT_LEVEL;
    end else if (w_synced == r_level) begin
      r_count <= '0;
    end else if (r_count == CNT_LAST) begin
      r_count <= '0;
      r_level <= w_synced;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Delayed copy of the accepted level so a flip shows up as a one-cycle pulse the cycle after.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_levelPrev <= INIT_LEVEL;
    end else begin
      r_levelPrev <= r_level;
    end
  end

  assign o_raw   = w_synced;
  assign o_level = r_level;
  assign o_rise  = r_level & ~r_levelPrev;
  assign o_fall  = ~r_level & r_levelPrev;

endmodule

// File: rtl/avalon_debounced_key_pio.sv
// Avalon-MM input PIO for board keys/switches: per-bit debounce, selectable
// edge capture with write-1-to-clear flags, and a masked level interrupt.
module avalon_debounced_key_pio
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit INIT_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] r_riseEn;
  logic [WIDTH-1:0] r_fallEn;
  logic [WIDTH-1:0] r_irqMask;
  logic [WIDTH-1:0] r_edgeCap;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_newEdges;
  logic [WIDTH-1:0] w_clearMask;
  logic [WIDTH-1:0] w_wdata;
  logic [31:0]      w_readMux;
  logic             w_wrEn;
  logic             w_unusedWdata;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    key_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT_LEVEL     (INIT_LEVEL)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .i_pin  (in_port[gi]),
      .o_raw  (w_raw[gi]),
      .o_level(w_level[gi]),
      .o_rise (w_rise[gi]),
      .o_fall (w_fall[gi])
    );
  end

  assign w_wrEn        = chipselect & ~write_n;
  assign w_wdata       = writedata[WIDTH-1:0];
  assign w_unusedWdata = ^writedata;
  assign w_newEdges    = (w_rise & r_riseEn) | (w_fall & r_fallEn);
  assign w_clearMask   = (w_wrEn && (address == ADDR_EDGE_CAP)) ? w_wdata : '0;

  // Software-writable control registers; rising edges are captured by default after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_riseEn  <= '1;
      r_fallEn  <= '0;
      r_irqMask <= '0;
    end else if (w_wrEn) begin
      if (address == ADDR_RISE_EN)  r_riseEn  <= w_wdata;
      if (address == ADDR_FALL_EN)  r_fallEn  <= w_wdata;
      if (address == ADDR_IRQ_MASK) r_irqMask <= w_wdata;
    end
  end

  // Sticky edge flags: a new qualified edge wins over a simultaneous clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgeCap <= '0;
    end else begin
      r_edgeCap <= (r_edgeCap & ~w_clearMask) | w_newEdges;
    end
  end

  // Select the addressed register, zero-extended; unmapped words read as zero.
  always_comb begin
    w_readMux = '0;
    case (address)
      ADDR_DATA:     w_readMux = 32'(w_level);
      ADDR_RISE_EN:  w_readMux = 32'(r_riseEn);
      ADDR_IRQ_MASK: w_readMux = 32'(r_irqMask);
      ADDR_EDGE_CAP: w_readMux = 32'(r_edgeCap);
      ADDR_FALL_EN:  w_readMux = 32'(r_fallEn);
      ADDR_RAW:      w_readMux = 32'(w_raw);
      default:       w_readMux = '0;
    endcase
  end

  // Register read data every cycle, independent of chipselect, giving a fixed one-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_readMux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edgeCap & r_irqMask);

endmodule

// File: tb/tb_avalon_debounced_key_pio.sv
// Directed bench for the debounced key PIO with a 4-cycle debounce window.
module tb_avalon_debounced_key_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int passCount;
  int checkCount;

  avalon_debounced_key_pio #(
    .WIDTH          (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .INIT_LEVEL     (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] pins);
    in_port = pins;
  endtask

  task automatic busWrite(input logic [2:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic busRead(input logic [2:0] addr, output logic [31:0] data);
    address    = addr;
    chipselect = 1'b1;
    tick();
    chipselect = 1'b0;
    data       = readdata;
  endtask

  // Reset value of every word address.
  task automatic checkResetMap(input string prefix);
    logic [31:0] resetMap [8];
    logic [31:0] data;
    resetMap = '{32'hF, 32'hF, 32'h0, 32'h0, 32'h0, 32'hF, 32'h0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      busRead(3'(i), data);
      checkOutput($sformatf("%s_addr%0d", prefix, i), data, resetMap[i]);
    end
  endtask

  initial begin
    logic [31:0] data;
    logic        sawRaw;

    passCount  = 0;
    checkCount = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state of the register map and quiet interrupt with keys idle.
    checkResetMap("reset");
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("idle_irq", 32'(irq), 32'h0);
    end

    // Three-cycle glitch on key0: visible on RAW, filtered from DATA.
    address = 3'd5;
    applyStimulus(4'hE);
    sawRaw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (readdata == 32'hE) sawRaw = 1'b1;
      if (k == 3) applyStimulus(4'hF);
    end
    checkOutput("glitch_raw_seen", 32'(sawRaw), 32'h1);
    busRead(3'd0, data);
    checkOutput("glitch_data", data, 32'hF);
    busRead(3'd3, data);
    checkOutput("glitch_edgecap", data, 32'h0);

    // Falling edge on key0: level accepted 6 cycles after the pin moves, read one cycle later.
    busWrite(3'd4, 32'h1);
    busWrite(3'd2, 32'h1);
    address = 3'd0;
    tick();
    applyStimulus(4'hE);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) begin
        checkOutput("fall_data_before", readdata, 32'hF);
        checkOutput("fall_irq_before", 32'(irq), 32'h0);
      end
      if (k == 7) begin
        checkOutput("fall_data_after", readdata, 32'hE);
        checkOutput("fall_irq_after", 32'(irq), 32'h1);
      end
    end
    busRead(3'd3, data);
    checkOutput("fall_edgecap", data, 32'h1);
    repeat (3) tick();
    busWrite(3'd3, 32'h1);
    checkOutput("w1c_irq", 32'(irq), 32'h0);
    busRead(3'd3, data);
    checkOutput("w1c_edgecap", data, 32'h0);

    // Release key0 after narrowing the enables to key1: no flag for bit0.
    busWrite(3'd1, 32'h2);
    busWrite(3'd4, 32'h2);
    applyStimulus(4'hF);
    repeat (10) tick();
    busRead(3'd3, data);
    checkOutput("key0_release_cap", data, 32'h0);
    busRead(3'd0, data);
    checkOutput("key0_release_data", data, 32'hF);

    // Key1 press and release both captured; irq stays low while masked off.
    busWrite(3'd2, 32'h0);
    applyStimulus(4'hD);
    repeat (10) tick();
    busRead(3'd3, data);
    checkOutput("key1_press_cap", data, 32'h2);
    checkOutput("key1_press_irq", 32'(irq), 32'h0);
    busWrite(3'd3, 32'h2);
    busRead(3'd3, data);
    checkOutput("key1_clear", data, 32'h0);
    applyStimulus(4'hF);
    repeat (10) tick();
    busRead(3'd3, data);
    checkOutput("key1_release_cap", data, 32'h2);
    checkOutput("key1_release_irq", 32'(irq), 32'h0);
    busWrite(3'd2, 32'h2);
    checkOutput("mask_on_irq", 32'(irq), 32'h1);
    busWrite(3'd3, 32'h2);
    checkOutput("mask_clear_irq", 32'(irq), 32'h0);

    // W1C of bit2 lands on the same edge the bit2 falling edge is captured: set wins.
    busWrite(3'd4, 32'h6);
    applyStimulus(4'hB);
    repeat (6) tick();
    address    = 3'd3;
    writedata  = 32'h4;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    busRead(3'd3, data);
    checkOutput("collision_cap", data, 32'h4);
    busWrite(3'd3, 32'h4);
    busRead(3'd3, data);
    checkOutput("collision_clear", data, 32'h0);
    applyStimulus(4'hF);
    repeat (10) tick();
    busRead(3'd3, data);
    checkOutput("key2_release_cap", data, 32'h0);
    busRead(3'd0, data);
    checkOutput("key2_release_data", data, 32'hF);

    // Reset in the middle of a key3 debounce: everything returns to reset values.
    busWrite(3'd4, 32'hF);
    busWrite(3'd2, 32'hF);
    applyStimulus(4'h7);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_readdata", readdata, 32'h0);
    checkOutput("midreset_irq", 32'(irq), 32'h0);
    applyStimulus(4'hF);
    repeat (3) tick();
    reset_n = 1'b1;
    checkResetMap("postreset");
    repeat (10) tick();
    busRead(3'd3, data);
    checkOutput("postreset_cap", data, 32'h0);
    checkOutput("postreset_irq", 32'(irq), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
